// File: rtl/spi_command_sequencer.sv
// Drains 16-bit command words from the SPI receiver FIFO and sequences register writes
// and valid/ready burst memory writes, with busy and sticky error status.
module spi_command_sequencer #(
    parameter  int unsigned ADDR_WIDTH     = 16,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned WORD_W         = 16,
    localparam int unsigned REG_ADDR_W     = 8,
    localparam int unsigned CODE_W         = 2
) (
    input  logic                  aClock,
    input  logic                  aReset,
    input  logic                  aInDataAvailable,
    input  logic [WORD_W-1:0]     anInData,
    output logic                  anOutDataRead,
    output logic                  anOutRegWrite,
    output logic [REG_ADDR_W-1:0] anOutRegAddr,
    output logic [WORD_W-1:0]     anOutRegData,
    output logic                  anOutMemValid,
    input  logic                  aInMemReady,
    output logic [ADDR_WIDTH-1:0] anOutMemAddr,
    output logic [WORD_W-1:0]     anOutMemData,
    output logic                  anOutBusy,
    output logic                  anOutError,
    output logic [CODE_W-1:0]     anOutErrorCode,
    input  logic                  aClearError
);

    localparam int unsigned COUNT_W = 12;
    localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_WRITE_REG = 4'h1;
    localparam logic [3:0] OP_BURST     = 4'h2;

    localparam logic [CODE_W-1:0] ERR_NONE    = CODE_W'(0);
    localparam logic [CODE_W-1:0] ERR_OPCODE  = CODE_W'(1);
    localparam logic [CODE_W-1:0] ERR_TIMEOUT = CODE_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_REG_DATA,
        S_REG_WR,
        S_BURST_ADDR,
        S_BURST_DATA,
        S_MEM_WR
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_W-1:0]       cmd_q, cmd_d;
    logic [COUNT_W-1:0]      remain_q, remain_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;

    logic                    read_q, read_d;
    logic                    reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [WORD_W-1:0]       reg_data_q, reg_data_d;
    logic                    mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]       mem_data_q, mem_data_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [CODE_W-1:0]       code_q, code_d;

    logic                    fetch_state_c;
    logic                    wait_state_c;
    logic                    pop_c;
    logic                    bad_op_c;
    logic                    timeout_c;

    // A pop is never issued in the cycle right after another, since the FIFO head
    // only settles once the previous strobe has been seen.
    always_comb begin
        wait_state_c  = (state_q == S_REG_DATA) || (state_q == S_BURST_ADDR) ||
                        (state_q == S_BURST_DATA);
        fetch_state_c = wait_state_c || (state_q == S_IDLE);
        pop_c         = fetch_state_c && aInDataAvailable && !read_q;
    end

    always_ff @(posedge aClock) begin
        if (aReset) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            remain_q    <= '0;
            tmo_q       <= '0;
            read_q      <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            remain_q    <= remain_d;
            tmo_q       <= tmo_d;
            read_q      <= read_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    // Next state, command/count capture and payload starvation timeout.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        remain_d  = remain_q;
        tmo_d     = tmo_q;
        bad_op_c  = 1'b0;
        timeout_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    cmd_d   = anInData;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cmd_q[15:12])
                    OP_NOP:       state_d = S_IDLE;
                    OP_WRITE_REG: state_d = S_REG_DATA;
                    OP_BURST:     state_d = S_BURST_ADDR;
                    default: begin
                        bad_op_c = 1'b1;
                        state_d  = S_IDLE;
                    end
                endcase
            end
            S_REG_DATA: begin
                if (pop_c) state_d = S_REG_WR;
            end
            S_REG_WR: state_d = S_IDLE;
            S_BURST_ADDR: begin
                if (pop_c) begin
                    remain_d = cmd_q[COUNT_W-1:0];
                    state_d  = (cmd_q[COUNT_W-1:0] == '0) ? S_IDLE : S_BURST_DATA;
                end
            end
            S_BURST_DATA: begin
                if (pop_c) state_d = S_MEM_WR;
            end
            S_MEM_WR: begin
                if (aInMemReady) begin
                    remain_d = remain_q - COUNT_W'(1);
                    state_d  = (remain_q == COUNT_W'(1)) ? S_IDLE : S_BURST_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wait_state_c) begin
            if (pop_c) begin
                tmo_d = '0;
            end else if (!aInDataAvailable && TMO_EN) begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_d == TMO_LIMIT) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
        end

        if (state_d != state_q) tmo_d = '0;
    end

    // Registered outputs derived from the upcoming state and this cycle's captures.
    always_comb begin
        read_d      = pop_c;
        reg_write_d = (state_d == S_REG_WR);
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        mem_valid_d = (state_d == S_MEM_WR);
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        busy_d      = (state_d != S_IDLE);
        err_d       = err_q;
        code_d      = code_q;

        if (state_q == S_REG_DATA && pop_c) begin
            reg_addr_d = cmd_q[REG_ADDR_W-1:0];
            reg_data_d = anInData;
        end
        if (state_q == S_BURST_ADDR && pop_c) mem_addr_d = ADDR_WIDTH'(anInData);
        if (state_q == S_BURST_DATA && pop_c) mem_data_d = anInData;
        if (state_q == S_MEM_WR && aInMemReady) mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);

        if (bad_op_c) begin
            err_d  = 1'b1;
            code_d = ERR_OPCODE;
        end else if (timeout_c) begin
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
        end else if (aClearError) begin
            err_d  = 1'b0;
            code_d = ERR_NONE;
        end
    end

    assign anOutDataRead  = read_q;
    assign anOutRegWrite  = reg_write_q;
    assign anOutRegAddr   = reg_addr_q;
    assign anOutRegData   = reg_data_q;
    assign anOutMemValid  = mem_valid_q;
    assign anOutMemAddr   = mem_addr_q;
    assign anOutMemData   = mem_data_q;
    assign anOutBusy      = busy_q;
    assign anOutError     = err_q;
    assign anOutErrorCode = code_q;

endmodule
